compress_tile_ctrl: RTL and testbench

- Sequences one 32-pixel RGBA tile at a time through the compression datapath: input tile → header/min-max register → residual stage → packer → downstream.
- Owns the valid/ready handshakes at both ends.
- Tracks the residual stage's fixed one-cycle latency.
- Chooses compressed or raw packing from the residual stage's compressable flag, guards the packer with a watchdog, and keeps per-frame statistics.

---
 rtl/compress_tile_ctrl_pkg.sv | 26 ++
 rtl/compress_tile_ctrl_if.sv | 40 ++++
 rtl/compress_tile_ctrl_stats.sv | 41 ++++
 rtl/compress_tile_ctrl.sv | 134 +++++++++++++
 tb/tb_compress_tile_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/compress_tile_ctrl_pkg.sv
// Shared types and default sizing for the tile compression controller.
//   TILE_PIXELS      : pixels per tile handled by the datapath (informational)
//   DEF_CNT_W        : default width of the per-frame statistics counters
//   DEF_PACK_TIMEOUT : default packer watchdog limit in cycles
//   DEF_TO_W         : default watchdog width, 2**DEF_TO_W > DEF_PACK_TIMEOUT
package compress_tile_ctrl_pkg;

  localparam int TILE_PIXELS      = 32;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_PACK_TIMEOUT = 64;
  localparam int DEF_TO_W         = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESID  = 3'd1,
    DECIDE = 3'd2,
    PACK   = 3'd3,
    EMIT   = 3'd4
  } ctrl_state_t;

  typedef enum logic {
    PACK_RAW  = 1'b0,
    PACK_COMP = 1'b1
  } pack_mode_t;

endpackage

// File: rtl/compress_tile_ctrl_if.sv
// Handshake and status bundle between the tile controller and its neighbours
// (upstream tile source, header/residual stage, packer, downstream sink).
//   master : controller side (drives ready/load/start/valid and statistics)
//   slave  : environment side (drives valid/last/flags/done/ready)
interface compress_tile_ctrl_if import compress_tile_ctrl_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             hr_load;
  logic             compressable;
  logic             force_raw;
  logic             pack_start;
  logic             pack_mode;
  logic             pack_done;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic             out_last;
  logic             frame_done;
  logic [CNT_W-1:0] tile_cnt;
  logic [CNT_W-1:0] comp_cnt;
  logic [CNT_W-1:0] raw_cnt;
  logic             pack_err;

  modport master (
    input  in_valid, in_last, compressable, force_raw, pack_done, out_ready,
    output in_ready, hr_load, pack_start, pack_mode, out_valid, out_mode,
           out_last, frame_done, tile_cnt, comp_cnt, raw_cnt, pack_err
  );

  modport slave (
    output in_valid, in_last, compressable, force_raw, pack_done, out_ready,
    input  in_ready, hr_load, pack_start, pack_mode, out_valid, out_mode,
           out_last, frame_done, tile_cnt, comp_cnt, raw_cnt, pack_err
  );

endinterface

// File: rtl/compress_tile_ctrl_stats.sv
// Per-frame statistics: tiles emitted, compressed tiles, raw tiles.
// Counters saturate at all-ones and clear on clr (frame end) or rst.
//   clk, rst : clock, synchronous active-high reset
//   inc      : one tile emitted this cycle
//   is_comp  : emitted tile was packed compressed
//   clr      : clear all counters
//   tile_cnt, comp_cnt, raw_cnt : counter values
module ctrl_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             is_comp,
  input  logic             clr,
  output logic [CNT_W-1:0] tile_cnt,
  output logic [CNT_W-1:0] comp_cnt,
  output logic [CNT_W-1:0] raw_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // clr and inc never coincide in practice (clr follows the last handshake
  // by a cycle); clear still takes priority.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tile_cnt <= '0;
      comp_cnt <= '0;
      raw_cnt  <= '0;
    end else if (inc) begin
      tile_cnt <= sat_inc(tile_cnt);
      if (is_comp) comp_cnt <= sat_inc(comp_cnt);
      else         raw_cnt  <= sat_inc(raw_cnt);
    end
  end

endmodule

// File: rtl/compress_tile_ctrl.sv
// Tile sequencer for the compression datapath: accepts one tile, waits out
// the residual stage, starts the packer in raw or compressed mode, guards it
// with a watchdog, hands the packed tile downstream and keeps frame stats.
//   clk, rst : clock, synchronous active-high reset
//   bus      : compress_tile_ctrl_if.master (all handshakes and status)
//
// state  | meaning
// IDLE   | ready for a new tile
// RESID  | residual stage computing; its output register loads this cycle
// DECIDE | choose pack mode, pulse pack_start, clear watchdog
// PACK   | waiting for pack_done, watchdog running
// EMIT   | packed tile offered downstream until out_ready
module compress_tile_ctrl import compress_tile_ctrl_pkg::*; #(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int PACK_TIMEOUT = DEF_PACK_TIMEOUT,
  parameter int TO_W         = DEF_TO_W
) (
  input  logic                clk,
  input  logic                rst,
  compress_tile_ctrl_if.master bus
);

  // Watchdog starts at 0 on PACK entry, so the count PACK_TIMEOUT-1 is the
  // last PACK cycle; leaving then puts EMIT exactly PACK_TIMEOUT cycles later.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(PACK_TIMEOUT - 1);

  ctrl_state_t     state_q, state_d;
  pack_mode_t      pack_mode_q, pack_mode_d;
  pack_mode_t      out_mode_q, out_mode_d;
  pack_mode_t      decide_mode;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic            frame_done_q, frame_done_d;
  logic            accept;
  logic            pack_start;
  logic            emit_hs;

  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.hr_load  = accept;

  assign decide_mode = (bus.compressable && !bus.force_raw) ? PACK_COMP : PACK_RAW;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pack_mode_q  <= PACK_RAW;
      out_mode_q   <= PACK_RAW;
      wd_q         <= '0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pack_mode_q  <= pack_mode_d;
      out_mode_q   <= out_mode_d;
      wd_q         <= wd_d;
      last_q       <= last_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pack_mode_d  = pack_mode_q;
    out_mode_d   = out_mode_q;
    wd_d         = wd_q;
    last_d       = last_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    pack_start   = 1'b0;
    emit_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_d  = bus.in_last;
          state_d = RESID;
        end
      end
      RESID: state_d = DECIDE;
      DECIDE: begin
        pack_start  = 1'b1;
        pack_mode_d = decide_mode;
        wd_d        = '0;
        state_d     = PACK;
      end
      PACK: begin
        // pack_done is checked first so a completion on the timeout cycle
        // is not flagged as an error.
        if (bus.pack_done) begin
          out_mode_d = pack_mode_q;
          state_d    = EMIT;
        end else if (wd_q == WD_LAST) begin
          out_mode_d = PACK_RAW;
          err_d      = 1'b1;
          state_d    = EMIT;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          emit_hs      = 1'b1;
          frame_done_d = last_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // During DECIDE the packer sees the freshly chosen mode alongside pack_start.
  assign bus.pack_mode  = (state_q == DECIDE) ? decide_mode : pack_mode_q;
  assign bus.pack_start = pack_start;
  assign bus.out_valid  = (state_q == EMIT);
  assign bus.out_last   = (state_q == EMIT) && last_q;
  assign bus.out_mode   = out_mode_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pack_err   = err_q;

  ctrl_stats #(.CNT_W(CNT_W)) u_stats (
    .clk      (clk),
    .rst      (rst),
    .inc      (emit_hs),
    .is_comp  (out_mode_q == PACK_COMP),
    .clr      (frame_done_q),
    .tile_cnt (bus.tile_cnt),
    .comp_cnt (bus.comp_cnt),
    .raw_cnt  (bus.raw_cnt)
  );

endmodule

// File: tb/tb_compress_tile_ctrl.sv
// Testbench for compress_tile_ctrl: a driver sequences tiles and plays the
// packer; expected emitted tiles go into a scoreboard queue that a monitor
// drains on each downstream handshake.
module tb_compress_tile_ctrl;
  import compress_tile_ctrl_pkg::*;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  compress_tile_ctrl_if #(.CNT_W(CNT_W)) bus ();

  compress_tile_ctrl #(.CNT_W(CNT_W), .PACK_TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit mode;
    bit last;
    bit err;
    int tile;
    int comp;
    int raw;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model: frame statistics and sticky error
  int m_tile = 0, m_comp = 0, m_raw = 0;
  bit m_err  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic int sat(input int v);
    int mx = (1 << CNT_W) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_push(input bit mode, input bit last);
    exp_t e;
    m_tile = sat(m_tile);
    if (mode) m_comp = sat(m_comp);
    else      m_raw  = sat(m_raw);
    e = '{mode: mode, last: last, err: m_err, tile: m_tile, comp: m_comp, raw: m_raw};
    sb.push_back(e);
    if (last) begin
      m_tile = 0; m_comp = 0; m_raw = 0;
    end
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_emit: tile emitted with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("out_mode", bus.out_mode, e.mode);
          chk("out_last", bus.out_last, e.last);
          chk("pack_err", bus.pack_err, e.err);
          @(negedge clk);
          chk("frame_done", bus.frame_done, e.last);
          chk("tile_cnt", bus.tile_cnt, e.tile);
          chk("comp_cnt", bus.comp_cnt, e.comp);
          chk("raw_cnt", bus.raw_cnt, e.raw);
          if (e.last) begin
            @(negedge clk);
            chk("frame_done_one_cycle", bus.frame_done, 0);
            chk("tile_cnt_cleared", bus.tile_cnt, 0);
            chk("comp_cnt_cleared", bus.comp_cnt, 0);
            chk("raw_cnt_cleared", bus.raw_cnt, 0);
          end
        end
      end
    end
  end

  // delay: packer cycles from pack_start to pack_done (1..TIMEOUT), <0 = never
  task automatic run_tile(input bit comp, input bit fr, input bit last,
                          input int delay, input int stall, input bit stray);
    int t0, ts, t_out;
    bit ok, timeout, exp_mode, dec_mode, v_mode, v_last;
    int v_tile;
    timeout  = (delay < 0);
    dec_mode = comp && !fr;
    exp_mode = timeout ? 1'b0 : dec_mode;

    @(posedge clk); #1;
    if (stray) begin
      bus.pack_done = 1'b1;
      @(posedge clk); #1;
      bus.pack_done = 1'b0;
    end
    bus.in_valid     = 1'b1;
    bus.in_last      = last;
    bus.compressable = comp;
    bus.force_raw    = fr;
    bus.out_ready    = (stall == 0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      bound_fail("accept");
      bus.in_valid = 1'b0;
      return;
    end
    t0 = cyc;
    chk("hr_load_on_accept", bus.hr_load, 1);
    if (timeout) m_err = 1'b1;
    model_push(exp_mode, last);

    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'($urandom_range(0, 1));
    bus.pack_done = stray;
    @(negedge clk);
    chk("in_ready_busy", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.pack_done = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.pack_start) begin ok = 1'b1; break; end
    end
    if (!ok) begin bound_fail("pack_start"); return; end
    ts = cyc;
    chk("accept_to_start", ts - t0, 2);
    chk("pack_mode_at_start", bus.pack_mode, dec_mode);

    @(posedge clk); #1;
    bus.compressable = 1'($urandom_range(0, 1));
    bus.force_raw    = 1'($urandom_range(0, 1));
    if (!timeout) begin
      repeat (delay - 1) @(posedge clk);
      #1;
      bus.pack_done = 1'b1;
      @(negedge clk);
      chk("pack_mode_held", bus.pack_mode, dec_mode);
      @(posedge clk); #1;
      bus.pack_done = 1'b0;
    end

    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin bound_fail("out_valid"); bus.out_ready = 1'b1; return; end
    t_out = cyc;
    chk("start_to_emit", t_out - ts, timeout ? TIMEOUT + 1 : delay + 1);

    if (stall > 0) begin
      v_mode = bus.out_mode;
      v_last = bus.out_last;
      v_tile = int'(bus.tile_cnt);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_mode", bus.out_mode, v_mode);
        chk("stall_last", bus.out_last, v_last);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_tile_cnt", bus.tile_cnt, v_tile);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
    end
  endtask

  task automatic reset_during_pack();
    bit ok;
    @(posedge clk); #1;
    bus.in_valid     = 1'b1;
    bus.in_last      = 1'b1;
    bus.compressable = 1'b1;
    bus.force_raw    = 1'b0;
    bus.out_ready    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) bound_fail("rst_accept");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_during_rst", bus.in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_tile = 0; m_comp = 0; m_raw = 0; m_err = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_hr_load", bus.hr_load, 0);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_pack_start", bus.pack_start, 0);
    chk("post_rst_pack_mode", bus.pack_mode, 0);
    chk("post_rst_out_mode", bus.out_mode, 0);
    chk("post_rst_out_last", bus.out_last, 0);
    chk("post_rst_frame_done", bus.frame_done, 0);
    chk("post_rst_pack_err", bus.pack_err, 0);
    chk("post_rst_tile_cnt", bus.tile_cnt, 0);
    chk("post_rst_comp_cnt", bus.comp_cnt, 0);
    chk("post_rst_raw_cnt", bus.raw_cnt, 0);
    @(posedge clk); #1;
    bus.pack_done = 1'b1;
    @(posedge clk); #1;
    bus.pack_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("late_done_no_emit", bus.out_valid, 0);
      chk("late_done_idle", bus.in_ready, 1);
    end
  endtask

  // global guard
  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_last      = 1'b0;
    bus.compressable = 1'b0;
    bus.force_raw    = 1'b0;
    bus.pack_done    = 1'b0;
    bus.out_ready    = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_pack_start", bus.pack_start, 0);
    chk("rst_pack_err", bus.pack_err, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_tile_cnt", bus.tile_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_hr_load", bus.hr_load, 0);

    run_tile(1, 0, 1, 5, 0, 0);      // single compressed tile, frame end
    run_tile(1, 1, 1, 3, 0, 0);      // force_raw overrides compressable
    run_tile(0, 0, 0, 2, 0, 1);      // three back-to-back, stray pack_done
    run_tile(1, 0, 0, 1, 0, 1);
    run_tile(1, 0, 1, 4, 0, 1);
    run_tile(1, 0, 1, 4, 10, 0);     // downstream stall
    run_tile(1, 0, 0, TIMEOUT, 0, 0); // done on the timeout cycle wins
    run_tile(1, 0, 0, -1, 0, 0);     // watchdog fires
    run_tile(1, 0, 0, 3, 0, 0);      // error stays sticky
    run_tile(0, 0, 1, 2, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_tile(1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 20)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
               1'($urandom_range(0, 1)));
    end

    run_tile(1, 0, 0, 2, 0, 0);      // leave a frame open before reset
    run_tile(1, 0, 0, -1, 0, 0);
    reset_during_pack();
    run_tile(1, 0, 1, 3, 0, 0);      // recovery after reset

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
